// File: rtl/fetch_cycle.sv
// fetch_cycle: RV32 instruction-fetch stage with PC, imem request port and IF/ID register.
// Handles stalls, execute redirects and variable-latency memory by inserting NOP bubbles.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instructionF,
    output logic [31:0] PCF,
    output logic        ValidF,
    output logic        FetchBusyF
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DISCARD = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic [31:0] hold_buf;
    logic        hs;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        deliver;
    logic        bubble;
    logic [31:0] deliver_data;

    // Request port and busy flag follow the state; the address is the current PC
    assign imem_req   = (state != S_HOLD);
    assign imem_addr  = pc;
    assign hs         = imem_req & imem_ready;
    assign target     = PCTargetE & 32'hFFFF_FFFC;
    assign pc_plus4   = pc + 32'd4;
    assign FetchBusyF = (state == S_DISCARD) |
                        ((state == S_FETCH) & ~imem_ready);

    // Decide what IF/ID receives this cycle: a real instruction, a bubble, or nothing
    always_comb begin
        deliver      = 1'b0;
        bubble       = 1'b0;
        deliver_data = hold_buf;
        unique case (state)
            S_FETCH: begin
                if (hs) begin
                    if (PCSrcE) begin
                        bubble = 1'b1;
                    end else if (!StallF) begin
                        deliver      = 1'b1;
                        deliver_data = imem_rdata;
                    end
                end else begin
                    bubble = ~StallF;
                end
            end
            S_DISCARD: begin
                bubble = ~StallF;
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    bubble = 1'b1;
                end else if (!StallF) begin
                    deliver = 1'b1;
                end
            end
            default: begin
                bubble = 1'b1;
            end
        endcase
        if (FlushD) begin
            deliver = 1'b0;
            bubble  = 1'b1;
        end
    end

    // Fetch FSM: PC, pending redirect target and stall buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            redir_pc <= RESET_PC;
            hold_buf <= NOP_INSTR;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (hs) begin
                        if (PCSrcE) begin
                            pc <= target;
                        end else if (StallF) begin
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end else if (PCSrcE) begin
                        redir_pc <= target;
                        state    <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (hs) begin
                        pc    <= PCSrcE ? target : redir_pc;
                        state <= S_FETCH;
                    end else if (PCSrcE) begin
                        redir_pc <= target;
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        pc    <= target;
                        state <= S_FETCH;
                    end else if (!StallF) begin
                        pc    <= pc_plus4;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instructionF <= NOP_INSTR;
            PCF          <= 32'd0;
            ValidF       <= 1'b0;
        end else if (deliver) begin
            instructionF <= deliver_data;
            PCF          <= pc;
            ValidF       <= 1'b1;
        end else if (bubble) begin
            instructionF <= NOP_INSTR;
            PCF          <= 32'd0;
            ValidF       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: directed and randomized checks of fetch_cycle against
// a transaction-level fetch model; memory returns addr+0x100.
module tb_fetch_cycle;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, FlushD, PCSrcE, imem_ready;
    logic [31:0] PCTargetE;
    logic        imem_req, ValidF, FetchBusyF;
    logic [31:0] imem_addr, imem_rdata, instructionF, PCF;

    int checks = 0;
    int errors = 0;

    // model: next address to fetch, what the fetch unit is doing, IF/ID contents
    logic [31:0] m_pc, m_redir, m_buf;
    int          m_mode;
    logic [31:0] m_instr, m_pcf;
    logic        m_valid;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr + 32'h100;

    fetch_cycle dut (
        .clk(clk), .reset(reset), .StallF(StallF), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instructionF(instructionF), .PCF(PCF),
        .ValidF(ValidF), .FetchBusyF(FetchBusyF)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_redir = 32'h0;
        m_buf   = NOP;
        m_mode  = 0;
        m_instr = NOP;
        m_pcf   = 32'h0;
        m_valid = 1'b0;
    endtask

    // mode 0: fetching m_pc, 1: waiting to drop a stale response, 2: holding a fetched word
    task automatic model_edge(input logic st, fl, ps,
                              input logic [31:0] tg, input logic rdy);
        logic        hs, dlv, bub;
        logic [31:0] dd, dp, t;
        hs  = (m_mode != 2) && rdy;
        t   = {tg[31:2], 2'b00};
        dlv = 1'b0;
        bub = 1'b0;
        dd  = 32'h0;
        dp  = 32'h0;
        if (m_mode == 0) begin
            if (hs && ps) begin
                m_pc = t; bub = 1'b1;
            end else if (hs && st) begin
                m_buf = m_pc + 32'h100; m_mode = 2;
            end else if (hs) begin
                dlv = 1'b1; dd = m_pc + 32'h100; dp = m_pc; m_pc = m_pc + 4;
            end else begin
                if (ps) begin m_redir = t; m_mode = 1; end
                bub = !st;
            end
        end else if (m_mode == 1) begin
            if (ps) m_redir = t;
            if (hs) begin m_pc = m_redir; m_mode = 0; end
            bub = !st;
        end else begin
            if (ps) begin
                m_pc = t; m_mode = 0; bub = 1'b1;
            end else if (!st) begin
                dlv = 1'b1; dd = m_buf; dp = m_pc; m_pc = m_pc + 4; m_mode = 0;
            end
        end
        if (fl) begin dlv = 1'b0; bub = 1'b1; end
        if (dlv) begin
            m_instr = dd; m_pcf = dp; m_valid = 1'b1;
        end else if (bub) begin
            m_instr = NOP; m_pcf = 32'h0; m_valid = 1'b0;
        end
    endtask

    // one cycle: drive inputs, check request side, clock, check IF/ID
    task automatic step(input logic st, fl, ps,
                        input logic [31:0] tg, input logic rdy);
        StallF = st; FlushD = fl; PCSrcE = ps; PCTargetE = tg; imem_ready = rdy;
        #1;
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_mode != 2});
        if (m_mode != 2) chk("imem_addr", imem_addr, m_pc);
        chk("FetchBusyF", {31'h0, FetchBusyF},
            {31'h0, (m_mode == 1) || (m_mode == 0 && !rdy)});
        model_edge(st, fl, ps, tg, rdy);
        @(posedge clk);
        #1;
        chk("instructionF", instructionF, m_instr);
        chk("PCF", PCF, m_pcf);
        chk("ValidF", {31'h0, ValidF}, {31'h0, m_valid});
    endtask

    task automatic run(input int n, input logic st, fl, ps,
                       input logic [31:0] tg, input logic rdy);
        for (int i = 0; i < n; i++) step(st, fl, ps, tg, rdy);
    endtask

    initial begin
        StallF = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; imem_ready = 1;
        reset = 1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_instr", instructionF, 32'h13);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_valid", {31'h0, ValidF}, 32'h0);
        reset = 0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);

        // streaming
        step(0, 0, 0, 0, 1);
        chk("s0_instr", instructionF, 32'h100);
        chk("s0_pcf", PCF, 32'h0);
        run(2, 0, 0, 0, 0, 1);
        chk("s2_instr", instructionF, 32'h108);
        chk("s2_pcf", PCF, 32'h8);
        step(0, 0, 0, 0, 1);
        chk("pre_stall_addr", imem_addr, 32'h10);

        // stall at PC=0x10 for 3 cycles
        run(3, 1, 0, 0, 0, 1);
        chk("stall_pcf", PCF, 32'hC);
        chk("stall_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 1);
        chk("unstall_pcf", PCF, 32'h10);
        chk("unstall_instr", instructionF, 32'h110);
        step(0, 0, 0, 0, 1);
        chk("after_unstall_pcf", PCF, 32'h14);

        // slow memory: ready every 3rd cycle
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, (i % 3) == 2);

        // redirect during wait
        step(0, 0, 1, 32'h40, 1);
        step(0, 0, 1, 32'h203, 0);
        chk("disc_addr", imem_addr, 32'h40);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("redir_addr", imem_addr, 32'h200);
        step(0, 0, 0, 0, 1);
        chk("redir_pcf", PCF, 32'h200);
        chk("redir_instr", instructionF, 32'h300);

        // double redirect in DISCARD
        step(0, 0, 1, 32'h300, 0);
        step(0, 0, 1, 32'h400, 0);
        step(0, 0, 0, 0, 1);
        chk("dbl_addr", imem_addr, 32'h400);
        step(0, 0, 0, 0, 1);
        chk("dbl_pcf", PCF, 32'h400);

        // redirect in HOLD
        step(1, 0, 0, 0, 1);
        step(1, 0, 1, 32'h500, 1);
        step(0, 0, 0, 0, 1);
        chk("hold_redir_pcf", PCF, 32'h500);

        // flush with stall
        step(1, 1, 0, 0, 1);
        chk("flush_valid", {31'h0, ValidF}, 32'h0);
        chk("flush_instr", instructionF, 32'h13);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // async reset mid-transaction
        step(0, 0, 0, 0, 0);
        StallF = 0; FlushD = 0; PCSrcE = 0; imem_ready = 0;
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("arst_instr", instructionF, 32'h13);
        chk("arst_pcf", PCF, 32'h0);
        chk("arst_valid", {31'h0, ValidF}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        step(0, 0, 0, 0, 1);
        chk("arst_first", instructionF, 32'h100);

        // randomized
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_cycle.md
# fetch_cycle

Instruction-fetch stage of the 5-stage RV32 pipeline, directly upstream of the decode stage. It owns the program counter and drives a valid/ready instruction-memory request port. It holds the IF/ID pipeline register whose `instructionF`/`PCF` outputs feed decode. It absorbs hazard-unit stalls, taken-branch/jump redirects from execute and variable-latency memory, and inserts NOP bubbles wherever no valid instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `StallF`  in  1  hazard unit: hold PC and IF/ID.
- `FlushD`  in  1  hazard unit: clear IF/ID to bubble.
- `PCSrcE`  in  1  execute: redirect fetch to `PCTargetE`.
- `PCTargetE`  in  32  redirect target; bits [1:0] are forced to 0.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction.
- `instructionF`  out  32  IF/ID instruction to decode.
- `PCF`  out  32  IF/ID PC to decode.
- `ValidF`  out  1  IF/ID holds a real instruction, not a bubble.
- `FetchBusyF`  out  1  no instruction delivered this cycle because memory has not responded yet.

## Operation
- A handshake occurs on a rising edge with `imem_req & imem_ready`. While `imem_req=1`, `imem_addr` stays stable until the handshake.
- Redirect priority: `reset` > `PCSrcE` > `StallF`. For IF/ID, `FlushD` overrides `StallF`.
- **State FETCH**: `imem_req=1`, `imem_addr=PC`.
  - Handshake with `PCSrcE`: data is discarded, PC <= target, IF/ID <= bubble, remain in FETCH.
  - Handshake with `StallF`: `imem_rdata` goes into the hold buffer; PC and IF/ID are held; go to HOLD.
  - Handshake, otherwise: IF/ID <= {`imem_rdata`, PC}, `ValidF`=1, PC <= PC+4.
  - No handshake with `PCSrcE`: latch target into `redir_pc` and go to DISCARD.
  - No handshake, otherwise: IF/ID <= bubble unless `StallF`; `FetchBusyF`=1.
- **State DISCARD**: `imem_req=1`, `imem_addr` = old PC.
  - A further `PCSrcE` overwrites `redir_pc`.
  - On handshake, data is dropped, PC <= `redir_pc`, go to FETCH.
  - IF/ID <= bubble each cycle unless `StallF`; `FetchBusyF`=1.
- **State HOLD**: `imem_req=0`.
  - `PCSrcE`: drop buffer, PC <= target, IF/ID <= bubble, go to FETCH.
  - Else `!StallF`: IF/ID <= {buffer, PC}, `ValidF`=1, PC <= PC+4, go to FETCH.
  - Else hold.
- Bubble: `instructionF=NOP_INSTR`, `PCF=0`, `ValidF=0`.
- `FlushD` forces a bubble into IF/ID in any state. It does not move PC or change state.
- PC+4 wraps modulo 2^32. `PCTargetE[1:0]` is ignored.

## Timing
- Reset, asynchronous:
  - PC=`RESET_PC`, state=FETCH.
  - `instructionF=NOP_INSTR`, `PCF=0`, `ValidF=0`.
  - `imem_req=1` and `imem_addr=RESET_PC` from the first cycle after reset deassertion.
  - Reset mid-request abandons the transaction.
- With `imem_ready` tied high: one instruction per cycle. The instruction at address A appears on `instructionF` one edge after `imem_addr=A`.
- Redirect penalty with single-cycle memory:
  - The target is requested in the cycle after `PCSrcE`.
  - One bubble is generated by fetch; decode/execute bubbles are the hazard unit's job via `FlushD`/FlushE.
- Memory latency N cycles: N-1 bubbles per instruction, with `FetchBusyF` high in those cycles.
- `FetchBusyF` and `imem_req` are combinational from state. All other outputs are registered.

## Test plan
- **Reset/streaming**: reset with `imem_ready=1`, memory returning addr+0x100 → `instructionF` = 0x100, 0x104, 0x108… with `PCF` = 0, 4, 8; `ValidF`=1 from the second edge.
- **Stall**: assert `StallF` for 3 cycles at PC=0x10 → `PCF`/`instructionF` hold the 0x0C entry; `imem_addr` holds or drops `imem_req` (HOLD); after release, 0x10 is delivered exactly once, with no skip or duplicate.
- **Slow memory**: `imem_ready` high every 3rd cycle → 2 bubbles (`ValidF=0`, `instructionF=0x00000013`) per instruction; `FetchBusyF`=1 in those cycles; `imem_addr` stable throughout.
- **Redirect during wait**: `PCSrcE=1`, `PCTargetE=0x203` while a request to 0x40 is pending → 0x40 data is discarded; next request is 0x200; next valid `PCF`=0x200.
- **Redirect in HOLD and double redirect in DISCARD**: targets 0x300 then 0x400 → only 0x400 is fetched; the buffer is never delivered.
- **Flush with stall, and async reset mid-transaction**: `FlushD=1` with `StallF=1` → bubble. Reset asserted mid-transaction → outputs reset immediately, without waiting for a clock edge.
